// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_responder: wait-state data memory slave for a processor memory stage.  |
// | Optional MMIO (LEDs/Switches) via `define DMEM_MMIO_EN.                     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemReadyM,
  output logic        ErrM,
  output logic [7:0]  LEDs,
  input  logic [2:0]  Switches
);

  localparam int c_AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       state_q;
  logic [3:0]   cnt_q;
  logic         write_q;
  logic [29:0]  waddr_q;
  logic [31:0]  wdata_q;
  logic [31:0]  rdata_q;
  logic         ready_q;
  logic         err_q;
  logic [31:0]  mem_q [DEPTH_WORDS];

  logic            w_accept;
  logic            w_exec;
  logic            w_write;
  logic [29:0]     w_waddr;
  logic [31:0]     w_wdata;
  logic [c_AW-1:0] w_idx;
  logic            w_inrange;
  logic            w_mmio_hit;
  logic            w_mmio_led;
  logic [31:0]     w_mmio_rdata;
  logic            w_unused;

  // With zero wait states the access runs on the accept edge itself, so the
  // live request feeds the datapath; otherwise the latched copy does.
  assign w_accept  = (state_q == S_IDLE) && MemReqM;
  assign w_exec    = (WAIT_STATES == 0) ? w_accept
                                        : ((state_q == S_WAIT) && (cnt_q == 4'd1));
  assign w_write   = (state_q == S_IDLE) ? MemWriteM   : write_q;
  assign w_waddr   = (state_q == S_IDLE) ? AddrM[31:2] : waddr_q;
  assign w_wdata   = (state_q == S_IDLE) ? WriteDataM  : wdata_q;
  assign w_idx     = w_waddr[c_AW-1:0];
  assign w_inrange = (w_waddr[29:c_AW] == '0);

`ifdef DMEM_MMIO_EN
  localparam logic [29:0] c_LED_WADDR = 30'h3FFF_FFC0;
  localparam logic [29:0] c_SW_WADDR  = 30'h3FFF_FFC1;

  logic [7:0] leds_q;

  assign w_mmio_led   = (w_waddr == c_LED_WADDR);
  assign w_mmio_hit   = w_mmio_led || (w_waddr == c_SW_WADDR);
  assign w_mmio_rdata = w_mmio_led ? {24'b0, leds_q} : {29'b0, Switches};
  assign LEDs         = leds_q;
  assign w_unused     = ^AddrM[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q <= 8'd0;
    end else if (w_exec && w_write && w_mmio_led) begin
      leds_q <= w_wdata[7:0];
    end
  end
`else
  assign w_mmio_led   = 1'b0;
  assign w_mmio_hit   = 1'b0;
  assign w_mmio_rdata = 32'd0;
  assign LEDs         = 8'd0;
  assign w_unused     = ^{Switches, AddrM[1:0], w_mmio_led};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= w_exec;
      case (state_q)
        S_IDLE: begin
          if (MemReqM) begin
            write_q <= MemWriteM;
            waddr_q <= AddrM[31:2];
            wdata_q <= WriteDataM;
            if (WAIT_STATES == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(WAIT_STATES);
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (w_exec) begin
        err_q <= !(w_inrange || w_mmio_hit);
        if (!w_write) begin
          rdata_q <= w_mmio_hit ? w_mmio_rdata :
                     w_inrange  ? mem_q[w_idx] : 32'd0;
        end
      end
    end
  end

  // The array is deliberately outside the reset domain; reset only gates commits.
  always_ff @(posedge clk) begin
    if (!reset && w_exec && w_write && w_inrange) begin
      mem_q[w_idx] <= w_wdata;
    end
  end

  assign ReadDataM = rdata_q;
  assign MemReadyM = ready_q;
  assign ErrM      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_responder: three responders (WS=1/D=256, WS=0/D=256, WS=3/D=16)     |
// | against a behavioural memory model. Revision: 1.0                           |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int N = 3;

  logic              clk;
  logic [N-1:0]      rst;
  logic [N-1:0]      req;
  logic [N-1:0]      we;
  logic [31:0]       addr  [N];
  logic [31:0]       wdata [N];
  logic [31:0]       rdata [N];
  logic [N-1:0]      ready;
  logic [N-1:0]      err;
  logic [7:0]        leds  [N];
  logic [2:0]        sw    [N];

  logic [31:0]       mem_m [N][256];
  logic [31:0]       rd_m  [N];
  logic [N-1:0]      err_m;
  logic [7:0]        led_m [N];

  int passed = 0;
  int total  = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS((g == 2) ? 16 : 256),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk        (clk),
      .reset      (rst[g]),
      .MemReqM    (req[g]),
      .MemWriteM  (we[g]),
      .AddrM      (addr[g]),
      .WriteDataM (wdata[g]),
      .ReadDataM  (rdata[g]),
      .MemReadyM  (ready[g]),
      .ErrM       (err[g]),
      .LEDs       (leds[g]),
      .Switches   (sw[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  function automatic int depth_of(input int d);
    return (d == 2) ? 16 : 256;
  endfunction

  // Reference: decode by address class, update the memory image and the
  // values the responder is expected to present after completion.
  task automatic model_op(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    logic [29:0] w;
    bit mled;
    bit msw;
    w    = a[31:2];
    mled = 1'b0;
    msw  = 1'b0;
`ifdef DMEM_MMIO_EN
    mled = (a[31:2] == 30'h3FFF_FFC0);
    msw  = (a[31:2] == 30'h3FFF_FFC1);
`endif
    if (mled) begin
      err_m[d] = 1'b0;
      if (wr) led_m[d] = wd[7:0]; else rd_m[d] = {24'b0, led_m[d]};
    end else if (msw) begin
      err_m[d] = 1'b0;
      if (!wr) rd_m[d] = {29'b0, sw[d]};
    end else if ({2'b0, w} < 32'(depth_of(d))) begin
      err_m[d] = 1'b0;
      if (wr) mem_m[d][w[7:0]] = wd; else rd_m[d] = mem_m[d][w[7:0]];
    end else begin
      err_m[d] = 1'b1;
      if (!wr) rd_m[d] = 32'd0;
    end
  endtask

  // Issues one request from IDLE, waits (bounded) for completion, captures the
  // response and steps once more so the responder is back in IDLE.
  task automatic access(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input bit scramble, output int lat, output logic [31:0] rc, output logic ec);
    req[d] = 1'b1; we[d] = wr; addr[d] = a; wdata[d] = wd;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1 && scramble) begin
        addr[d] = $urandom; wdata[d] = $urandom; we[d] = 1'($urandom); req[d] = 1'($urandom);
      end
    end while (ready[d] !== 1'b1 && lat < 40);
    rc = rdata[d];
    ec = err[d];
    req[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = '1;
    repeat (3) @(posedge clk);
    #1;
    rst = '0;
    for (int d = 0; d < N; d++) begin
      rd_m[d] = 32'd0; err_m[d] = 1'b0; led_m[d] = 8'd0;
      total++; if (rdata[d] !== 32'd0) $display("FAIL reset_rdata d%0d: got %h want 0", d, rdata[d]); else passed++;
      total++; if (ready[d] !== 1'b0)  $display("FAIL reset_ready d%0d: got %b want 0", d, ready[d]); else passed++;
      total++; if (err[d] !== 1'b0)    $display("FAIL reset_err d%0d: got %b want 0", d, err[d]); else passed++;
      total++; if (leds[d] !== 8'd0)   $display("FAIL reset_leds d%0d: got %h want 0", d, leds[d]); else passed++;
    end
  endtask

  task automatic test_fill(input int d);
    int lat; logic [31:0] rc; logic ec; logic [31:0] wd;
    for (int w = 0; w < depth_of(d); w++) begin
      wd = $urandom;
      model_op(d, 1'b1, 32'(w) << 2, wd);
      access(d, 1'b1, 32'(w) << 2, wd, 1'b0, lat, rc, ec);
      total++; if (lat !== ws_of(d) + 1) $display("FAIL fill_lat d%0d w%0d: got %0d want %0d", d, w, lat, ws_of(d) + 1); else passed++;
      total++; if (ec !== 1'b0) $display("FAIL fill_err d%0d w%0d: got %b want 0", d, w, ec); else passed++;
    end
  endtask

  task automatic test_directed();
    int lat; logic [31:0] rc; logic ec;
    model_op(0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, rc, ec);
    total++; if (lat !== 2) $display("FAIL wr10_lat: got %0d want 2", lat); else passed++;
    total++; if (ec !== 1'b0) $display("FAIL wr10_err: got %b want 0", ec); else passed++;
    total++; if (rc !== rd_m[0]) $display("FAIL wr10_rdata_hold: got %h want %h", rc, rd_m[0]); else passed++;
    model_op(0, 1'b0, 32'h10, 32'h0);
    access(0, 1'b0, 32'h10, 32'h0, 1'b0, lat, rc, ec);
    total++; if (lat !== 2) $display("FAIL rd10_lat: got %0d want 2", lat); else passed++;
    total++; if (rc !== 32'hDEADBEEF) $display("FAIL rd10_data: got %h want deadbeef", rc); else passed++;
    total++; if (ec !== 1'b0) $display("FAIL rd10_err: got %b want 0", ec); else passed++;

    model_op(0, 1'b1, 32'h13, 32'h12345678);
    access(0, 1'b1, 32'h13, 32'h12345678, 1'b0, lat, rc, ec);
    model_op(0, 1'b0, 32'h10, 32'h0);
    access(0, 1'b0, 32'h10, 32'h0, 1'b0, lat, rc, ec);
    total++; if (rc !== 32'h12345678) $display("FAIL lowbits_data: got %h want 12345678", rc); else passed++;

    model_op(0, 1'b0, 32'h400, 32'h0);
    access(0, 1'b0, 32'h400, 32'h0, 1'b0, lat, rc, ec);
    total++; if (ec !== 1'b1) $display("FAIL oor_rd_err: got %b want 1", ec); else passed++;
    total++; if (rc !== 32'd0) $display("FAIL oor_rd_data: got %h want 0", rc); else passed++;
    model_op(0, 1'b1, 32'h400, 32'h1);
    access(0, 1'b1, 32'h400, 32'h1, 1'b0, lat, rc, ec);
    total++; if (ec !== 1'b1) $display("FAIL oor_wr_err: got %b want 1", ec); else passed++;
    model_op(0, 1'b0, 32'h0, 32'h0);
    access(0, 1'b0, 32'h0, 32'h0, 1'b0, lat, rc, ec);
    total++; if (rc !== mem_m[0][0]) $display("FAIL oor_wr_word0: got %h want %h", rc, mem_m[0][0]); else passed++;

    model_op(0, 1'b1, 32'hFFFF_FF00, 32'h1A5);
    access(0, 1'b1, 32'hFFFF_FF00, 32'h1A5, 1'b0, lat, rc, ec);
`ifdef DMEM_MMIO_EN
    total++; if (leds[0] !== 8'hA5) $display("FAIL led_wr: got %h want a5", leds[0]); else passed++;
    total++; if (ec !== 1'b0) $display("FAIL led_wr_err: got %b want 0", ec); else passed++;
`else
    total++; if (leds[0] !== 8'h00) $display("FAIL led_wr: got %h want 00", leds[0]); else passed++;
    total++; if (ec !== 1'b1) $display("FAIL led_wr_err: got %b want 1", ec); else passed++;
`endif
    sw[0] = 3'b101;
    model_op(0, 1'b0, 32'hFFFF_FF04, 32'h0);
    access(0, 1'b0, 32'hFFFF_FF04, 32'h0, 1'b0, lat, rc, ec);
`ifdef DMEM_MMIO_EN
    total++; if (rc !== 32'h5) $display("FAIL sw_rd: got %h want 00000005", rc); else passed++;
`else
    total++; if (rc !== 32'h0) $display("FAIL sw_rd: got %h want 00000000", rc); else passed++;
`endif
    total++; if (ec !== err_m[0]) $display("FAIL sw_rd_err: got %b want %b", ec, err_m[0]); else passed++;
  endtask

  task automatic test_back_to_back(input int d);
    int k; int cyc; int last;
    req[d] = 1'b1; we[d] = 1'b0; addr[d] = 32'h0;
    k = 0; cyc = 0; last = 0;
    while (k < 4 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (ready[d] === 1'b1) begin
        model_op(d, 1'b0, addr[d], 32'h0);
        total++; if (rdata[d] !== rd_m[d]) $display("FAIL b2b_data d%0d k%0d: got %h want %h", d, k, rdata[d], rd_m[d]); else passed++;
        total++;
        if ((k == 0 && cyc != ws_of(d) + 1) || (k != 0 && cyc - last != ws_of(d) + 2))
          $display("FAIL b2b_timing d%0d k%0d: got cycle %0d (prev %0d) want interval %0d", d, k, cyc, last, ws_of(d) + 2);
        else passed++;
        last = cyc;
        k++;
        addr[d] = 32'(k) << 2;
      end
    end
    req[d] = 1'b0;
    total++; if (k !== 4) $display("FAIL b2b_count d%0d: got %0d want 4", d, k); else passed++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort(input int d);
    int lat; logic [31:0] rc; logic ec; logic [31:0] old; bit seen;
    old = mem_m[d][2];
    req[d] = 1'b1; we[d] = 1'b1; addr[d] = 32'h8; wdata[d] = 32'h55;
    @(posedge clk); #1;
    req[d] = 1'b0;
    seen = 1'b0;
    if (ws_of(d) > 1) begin
      @(posedge clk); #1;
      seen = seen | ready[d];
    end
    rst[d] = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      seen = seen | ready[d];
    end
    rst[d] = 1'b0;
    rd_m[d] = 32'd0; err_m[d] = 1'b0; led_m[d] = 8'd0;
    total++; if (seen !== 1'b0) $display("FAIL abort_ready d%0d: got 1 want 0", d); else passed++;
    total++; if (rdata[d] !== 32'd0) $display("FAIL abort_rdata d%0d: got %h want 0", d, rdata[d]); else passed++;
    model_op(d, 1'b0, 32'h8, 32'h0);
    access(d, 1'b0, 32'h8, 32'h0, 1'b0, lat, rc, ec);
    total++; if (rc !== old) $display("FAIL abort_nowrite d%0d: got %h want %h", d, rc, old); else passed++;
  endtask

  task automatic test_reset_req_held(input int d);
    int lat; logic [31:0] rc; logic ec;
    req[d] = 1'b1; we[d] = 1'b0; addr[d] = 32'hC;
    rst[d] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[d] = 1'b0;
    rd_m[d] = 32'd0; err_m[d] = 1'b0; led_m[d] = 8'd0;
    model_op(d, 1'b0, 32'hC, 32'h0);
    access(d, 1'b0, 32'hC, 32'h0, 1'b0, lat, rc, ec);
    total++; if (lat !== ws_of(d) + 1) $display("FAIL held_lat d%0d: got %0d want %0d", d, lat, ws_of(d) + 1); else passed++;
    total++; if (rc !== rd_m[d]) $display("FAIL held_data d%0d: got %h want %h", d, rc, rd_m[d]); else passed++;
  endtask

  task automatic test_random(input int d, input int n);
    int lat; logic [31:0] rc; logic ec; logic [31:0] a; logic [31:0] wd; bit wr;
    for (int i = 0; i < n; i++) begin
      wr = 1'($urandom);
      wd = $urandom;
      case ($urandom_range(0, 5))
        0, 1, 2: a = (32'($urandom_range(0, depth_of(d) - 1)) << 2) | 32'($urandom_range(0, 3));
        3:       a = 32'(4 * depth_of(d)) + (32'($urandom_range(0, 15)) << 2);
        4:       a = $urandom;
        default: a = ($urandom_range(0, 1) != 0 ? 32'hFFFF_FF00 : 32'hFFFF_FF04) | 32'($urandom_range(0, 3));
      endcase
      sw[d] = 3'($urandom);
      model_op(d, wr, a, wd);
      access(d, wr, a, wd, 1'b1, lat, rc, ec);
      total++; if (lat !== ws_of(d) + 1) $display("FAIL rnd_lat d%0d a=%h: got %0d want %0d", d, a, lat, ws_of(d) + 1); else passed++;
      total++; if (ec !== err_m[d]) $display("FAIL rnd_err d%0d a=%h wr=%b: got %b want %b", d, a, wr, ec, err_m[d]); else passed++;
      total++; if (rc !== rd_m[d]) $display("FAIL rnd_rdata d%0d a=%h wr=%b: got %h want %h", d, a, wr, rc, rd_m[d]); else passed++;
      total++; if (rdata[d] !== rd_m[d] || err[d] !== err_m[d]) $display("FAIL rnd_hold d%0d: got %h/%b want %h/%b", d, rdata[d], err[d], rd_m[d], err_m[d]); else passed++;
      total++; if (leds[d] !== led_m[d]) $display("FAIL rnd_leds d%0d: got %h want %h", d, leds[d], led_m[d]); else passed++;
    end
  endtask

  initial begin
    rst = '1; req = '0; we = '0;
    for (int d = 0; d < N; d++) begin
      addr[d] = 32'd0; wdata[d] = 32'd0; sw[d] = 3'd0;
    end
    test_reset();
    for (int d = 0; d < N; d++) test_fill(d);
    test_directed();
    for (int d = 0; d < N; d++) test_back_to_back(d);
    test_reset_abort(0);
    test_reset_abort(2);
    for (int d = 0; d < N; d++) test_reset_req_held(d);
    for (int d = 0; d < N; d++) test_random(d, 60);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
